if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the next-PC logic.
- Holds the architectural PC register and issues word fetches to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents {pc, instr} to decode with valid/ready.
- Accepts redirects carrying the computed next PC (branch, jump, jump-register targets) and discards stale fetches.

---
 rtl/if_fetch_unit_pkg.sv | 23 ++
 rtl/if_fifo.sv | 60 ++++++
 rtl/if_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage encodings and defaults.
// FETCH_MISALIGN_CHK_EN widens the buffer entry by a misalign tag.
package ctrl_encode_def;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam int FETCH_W = 65;
`else
  localparam int FETCH_W = 64;
`endif

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Instruction buffer: synchronous FIFO, power-of-two depth.
// Head is read straight from storage flops, so it is registered.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC register, one-outstanding imem fetch, decode buffer.
// Define FETCH_MISALIGN_CHK_EN to tag fetches after a misaligned redirect.
module if_fetch_unit
  import ctrl_encode_def::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        id_misalign,
`endif
  output logic [31:0] fetch_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         run_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic [FETCH_W-1:0] fifo_head;
  logic [FETCH_W-1:0] fifo_wdata;
  logic               fifo_push;
  logic               fifo_pop;

  logic               outstanding;
  logic [CW:0]        used;
  logic               has_credit;
  logic               fire;

`ifdef FETCH_MISALIGN_CHK_EN
  logic        pend_q, pend_d;
  logic [31:0] orig_q, orig_d;
  logic        req_mis_q, req_mis_d;
`endif

  assign outstanding = (state_q != FETCH_IDLE);
  assign used        = {1'b0, fifo_cnt} + {{CW{1'b0}}, outstanding};
  assign has_credit  = ~fifo_full & (used < (CW+1)'(FIFO_DEPTH));

  assign imem_req  = run_q & (state_q == FETCH_IDLE)
                   & has_credit & ~redirect;
  assign imem_addr = pc_q;
  assign fetch_pc  = pc_q;
  assign fire      = imem_req & imem_ack;

  assign fifo_push = (state_q == FETCH_WAIT) & imem_rvalid & ~redirect;
  assign fifo_pop  = id_valid & id_ready & ~redirect;

`ifdef FETCH_MISALIGN_CHK_EN
  assign fifo_wdata  = {req_mis_q, req_pc_q, imem_rdata};
  assign id_misalign = fifo_head[64];
`else
  assign fifo_wdata  = {req_pc_q, imem_rdata};
`endif

  assign id_valid = ~fifo_empty;
  assign id_pc    = fifo_head[63:32];
  assign id_instr = fifo_head[31:0];

  if_fifo #(
    .WIDTH (FETCH_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata (fifo_wdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt),
    .head  (fifo_head)
  );

  // Next state: sequential fetch, response tracking, redirect override.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
    pend_d    = pend_q;
    orig_d    = orig_q;
    req_mis_d = req_mis_q;
`endif
    unique case (state_q)
      FETCH_IDLE: begin
        if (fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = FETCH_WAIT;
`ifdef FETCH_MISALIGN_CHK_EN
          req_mis_d = pend_q;
          if (pend_q) req_pc_d = orig_q;
`endif
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid)   state_d = FETCH_IDLE;
        else if (redirect) state_d = FETCH_DROP;
      end
      FETCH_DROP: begin
        if (imem_rvalid) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
`ifdef FETCH_MISALIGN_CHK_EN
    if (fifo_push) pend_d = 1'b0;
`endif
    if (redirect) begin
      pc_d = word_align(redirect_pc);
`ifdef FETCH_MISALIGN_CHK_EN
      pend_d = |redirect_pc[1:0];
      orig_d = redirect_pc;
`endif
    end
  end

  // Fetch FSM and PC registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      run_q    <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      pend_q    <= 1'b0;
      orig_q    <= '0;
      req_mis_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      run_q    <= 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
      pend_q    <= pend_d;
      orig_q    <= orig_d;
      req_mis_q <= req_mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with a small imem responder.
// Define FETCH_MISALIGN_CHK_EN to also exercise the misalign tag.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] fetch_pc;
  logic        mis_act;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        id_misalign;
  assign mis_act = id_misalign;
`else
  assign mis_act = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // memory responder controls and log
  int          budget  = 0;
  int          lat_cfg = 0;
  logic [31:0] addr_log [$];
  int          first_ack_cyc   = -1;
  int          first_valid_cyc = -1;

  // expected {misalign, pc, instr}
  logic [64:0] sbq [$];

  if_fetch_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
`ifdef FETCH_MISALIGN_CHK_EN
    .id_misalign (id_misalign),
`endif
    .fetch_pc    (fetch_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] fa,
                          input logic mis);
    sbq.push_back({mis, pc, memfn(fa)});
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sbq.size() != 0 || budget != 0) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s drain timeout pending=%0d", nm, sbq.size());
    end
    repeat (3) step();
  endtask

  // imem: ack sampled mid-cycle, rvalid lat_cfg cycles after the ack edge
  initial begin
    logic        pend;
    logic [31:0] paddr;
    int          lat;
    pend = 1'b0;
    paddr = '0;
    lat = 0;
    imem_ack = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rstn && imem_req && budget > 0 && !pend) begin
        imem_ack = 1'b1;
        budget--;
        pend  = 1'b1;
        paddr = imem_addr;
        lat   = lat_cfg;
        addr_log.push_back(imem_addr);
        if (first_ack_cyc < 0) first_ack_cyc = cyc;
      end
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memfn(paddr);
          pend = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  // monitor: compare each accepted head against the scoreboard
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (rstn && id_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (id_ready && !redirect) begin
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual pc=%h instr=%h required none",
                     id_pc, id_instr);
          end else begin
            e = sbq.pop_front();
            if ({mis_act, id_pc, id_instr} !== e) begin
              failures++;
              $display("FAIL sb_entry actual=%h/%h/%b required=%h/%h/%b",
                       id_pc, id_instr, mis_act, e[63:32], e[31:0], e[64]);
            end
          end
        end
      end
    end
  end

  initial begin
    int n0;
    int t;
    rstn = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'h0000_3000);
    step();
    rstn = 1'b1;
    id_ready = 1'b1;

    // streaming fetch, 1-cycle memory
    exp_push(32'h3000, 32'h3000, 1'b0);
    exp_push(32'h3004, 32'h3004, 1'b0);
    exp_push(32'h3008, 32'h3008, 1'b0);
    budget = 3;
    drain("stream");
    chk("ack_to_valid", 32'(first_valid_cyc - first_ack_cyc), 32'd2);

    // decode stall: only two entries buffered, no further requests
    id_ready = 1'b0;
    n0 = addr_log.size();
    exp_push(32'h300C, 32'h300C, 1'b0);
    exp_push(32'h3010, 32'h3010, 1'b0);
    exp_push(32'h3014, 32'h3014, 1'b0);
    exp_push(32'h3018, 32'h3018, 1'b0);
    budget = 4;
    repeat (5) step();
    @(negedge clk);
    chk("stall_head5", id_pc, 32'h300C);
    repeat (5) step();
    @(negedge clk);
    chk("stall_acks", 32'(addr_log.size() - n0), 32'd2);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_head10", id_pc, 32'h300C);
    step();
    id_ready = 1'b1;
    drain("stall_release");

    // redirect while waiting on a slow response
    n0 = addr_log.size();
    lat_cfg = 3;
    budget = 1;
    t = 0;
    while (addr_log.size() == n0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    redirect = 1'b1;
    redirect_pc = 32'h0040_0010;
    step();
    redirect = 1'b0;
    lat_cfg = 0;
    @(negedge clk);
    chk("redir_fetch_pc", fetch_pc, 32'h0040_0010);
    step();
    exp_push(32'h0040_0010, 32'h0040_0010, 1'b0);
    budget = 1;
    drain("redir_wait");
    chk("redir_addr", addr_log.size() > n0 + 1 ? addr_log[n0 + 1] : 32'hxxxx_xxxx,
        32'h0040_0010);

    // PC wrap
    n0 = addr_log.size();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    exp_push(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    exp_push(32'h0000_0000, 32'h0000_0000, 1'b0);
    budget = 2;
    drain("wrap");
    chk("wrap_addr0", addr_log.size() > n0 ? addr_log[n0] : 32'hxxxx_xxxx,
        32'hFFFF_FFFC);
    chk("wrap_addr1", addr_log.size() > n0 + 1 ? addr_log[n0 + 1] : 32'hxxxx_xxxx,
        32'h0000_0000);

    // redirect coincident with a pop, buffer full
    id_ready = 1'b0;
    n0 = addr_log.size();
    budget = 2;
    t = 0;
    while (addr_log.size() < n0 + 2 && t < 50) begin
      step();
      t++;
    end
    repeat (3) step();
    @(negedge clk);
    chk("full_valid", {31'd0, id_valid}, 32'd1);
    step();
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_6000;
    step();
    redirect = 1'b0;
    id_ready = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_pc", fetch_pc, 32'h0000_6000);
    step();
    exp_push(32'h6000, 32'h6000, 1'b0);
    budget = 1;
    id_ready = 1'b1;
    drain("flush_refetch");

`ifdef FETCH_MISALIGN_CHK_EN
    n0 = addr_log.size();
    redirect = 1'b1;
    redirect_pc = 32'h0000_3002;
    step();
    redirect = 1'b0;
    exp_push(32'h3002, 32'h3000, 1'b1);
    exp_push(32'h3004, 32'h3004, 1'b0);
    budget = 2;
    drain("misalign");
    chk("mis_addr", addr_log.size() > n0 ? addr_log[n0] : 32'hxxxx_xxxx,
        32'h0000_3000);
`endif

    chk("sb_left", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
